// File: rtl/mux_nx1_stream_if.sv
// Stream bundle between N producer channels, the mux and one consumer.
// Ports: in_data/in_valid/in_last/in_ready (N channels), out_data/out_valid/out_last/out_ch/out_ready.
// Modports: master = producer/consumer side, slave = the mux itself.
interface mux_nx1_stream_if #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
);
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_valid;
  logic [NUM_CH-1:0]        in_last;
  logic [NUM_CH-1:0]        in_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [SEL_W-1:0]         out_ch;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, out_ch
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, out_ch
  );
endinterface

// File: rtl/mux_nx1_stream.sv
// N:1 packet-locked stream mux, manual select or packet-fair round-robin, registered output.
// Ports: clk, rst (sync, active high), mode (0 manual / 1 rr), sel, bus (slave side of mux_nx1_stream_if).
// Latency 1 cycle, 1 beat/cycle; in_ready is combinational and drops to 0 whenever the output slot is full.
module mux_nx1_stream #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  mux_nx1_stream_if.slave  bus
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  lock_state_t       state_q, state_d;
  logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [SEL_W-1:0]  out_ch_q;

  logic              slot_free;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_cur;
  logic              man_cand;
  logic              cand;
  logic [SEL_W-1:0]  cur;
  logic              cur_valid;
  logic              cur_last;
  logic [DATA_W-1:0] cur_data;
  logic              accept;
  logic [NUM_CH-1:0] ready;

  assign slot_free = !out_valid_q || bus.out_ready;

  // Round-robin scan starts one past the last packet's channel, so the
  // channel that just finished a packet comes last in priority.
  always_comb begin
    rr_found = 1'b0;
    rr_cur   = '0;
    for (int off = 1; off <= NUM_CH; off++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (!rr_found && bus.in_valid[k] && (k == (int'(rr_ptr_q) + off) % NUM_CH)) begin
          rr_found = 1'b1;
          rr_cur   = SEL_W'(k);
        end
      end
    end
  end

  // An out-of-range sel matches no channel, so it never produces a grant.
  always_comb begin
    man_cand = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) man_cand = bus.in_valid[k];
    end
  end

  always_comb begin
    if (state_q == LOCKED) begin
      cur  = lock_ch_q;
      cand = 1'b1;
    end else if (mode) begin
      cur  = rr_cur;
      cand = rr_found;
    end else begin
      cur  = sel;
      cand = man_cand;
    end
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = '0;
    ready     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cur == SEL_W'(k)) begin
        cur_valid = bus.in_valid[k];
        cur_last  = bus.in_last[k];
        cur_data  = bus.in_data[k*DATA_W +: DATA_W];
        ready[k]  = !rst && slot_free && cand;
      end
    end
  end

  assign accept       = !rst && slot_free && cand && cur_valid;
  assign bus.in_ready = ready;

  // Lock FSM and round-robin pointer: the pointer only moves on a last beat,
  // which makes arbitration fair per packet rather than per beat.
  always_comb begin
    state_d   = state_q;
    lock_ch_d = lock_ch_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      if (cur_last) begin
        state_d  = UNLOCKED;
        rr_ptr_d = cur;
      end else begin
        state_d   = LOCKED;
        lock_ch_d = cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      lock_ch_q   <= '0;
      rr_ptr_q    <= LAST_CH;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q   <= state_d;
      lock_ch_q <= lock_ch_d;
      rr_ptr_q  <= rr_ptr_d;
      if (accept) begin
        out_data_q  <= cur_data;
        out_last_q  <= cur_last;
        out_ch_q    <= cur;
        out_valid_q <= 1'b1;
      end else if (slot_free) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_nx1_stream.sv
// Bench for mux_nx1_stream: per-channel source queues feed the DUT, a monitor
// pops per-channel expected beats and an optional expected channel order.
module tb_mux_nx1_stream;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 2;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic [SEL_W-1:0] sel;

  mux_nx1_stream_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  mux_nx1_stream #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .mode (mode),
    .sel  (sel),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  beat_t             src_q[NUM_CH][$];
  beat_t             exp_q[NUM_CH][$];
  int                ord_q[$];
  logic [NUM_CH-1:0] fired;
  logic              gap_en = 1'b0;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int ch, input logic last, input logic [DATA_W-1:0] d);
    beat_t b;
    b.last = last;
    b.data = d;
    src_q[ch].push_back(b);
    exp_q[ch].push_back(b);
  endtask

  function automatic bit all_empty();
    bit e = 1'b1;
    for (int k = 0; k < NUM_CH; k++) if (exp_q[k].size() != 0) e = 1'b0;
    return e;
  endfunction

  // Source driver: a presented beat stays valid until taken; new beats may
  // be delayed by random gaps (also mid-packet) when gap_en is set.
  initial begin
    bus.in_valid = '0;
    bus.in_last  = '0;
    bus.in_data  = '0;
    forever begin
      @(negedge clk);
      fired = bus.in_valid & bus.in_ready;
      @(posedge clk);
      #2;
      for (int k = 0; k < NUM_CH; k++) begin
        if (fired[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() == 0) begin
          bus.in_valid[k] = 1'b0;
        end else begin
          if (!(bus.in_valid[k] && !fired[k]))
            bus.in_valid[k] = !gap_en || ($urandom_range(0, 3) != 0);
          bus.in_last[k]                  = src_q[k][0].last;
          bus.in_data[k*DATA_W +: DATA_W] = src_q[k][0].data;
        end
      end
    end
  end

  // Monitor / scoreboard.
  int                        pkt_ch = -1;
  logic                      prev_hold = 1'b0;
  logic [DATA_W+SEL_W+1:0]   prev_v;

  always @(negedge clk) begin
    int    c;
    beat_t e;
    if (rst) begin
      pkt_ch    = -1;
      prev_hold = 1'b0;
      chk("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
    end else begin
      chk("in_ready_onehot0", 32'($onehot0(bus.in_ready)), 32'd1);
      if (prev_hold)
        chk("stall_hold", 32'({bus.out_valid, bus.out_last, bus.out_ch, bus.out_data}), 32'(prev_v));
      if (bus.out_valid && !bus.out_ready)
        chk("in_ready_stalled", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) begin
        c = int'(bus.out_ch);
        chk("beat_expected", 32'(exp_q[c].size() > 0), 32'd1);
        if (exp_q[c].size() > 0) begin
          e = exp_q[c].pop_front();
          chk("beat_data", 32'({bus.out_last, bus.out_data}), 32'(e));
        end
        if (pkt_ch >= 0) chk("packet_lock", 32'(c), 32'(pkt_ch));
        pkt_ch = bus.out_last ? -1 : c;
        if (ord_q.size() > 0) chk("out_ch_order", 32'(c), 32'(ord_q.pop_front()));
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_v    = {bus.out_valid, bus.out_last, bus.out_ch, bus.out_data};
    end
  end

  task automatic clear_queues();
    for (int k = 0; k < NUM_CH; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
    end
    ord_q.delete();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_out_valid(input int budget, input string name);
    int i = 0;
    @(negedge clk);
    while (!bus.out_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk(name, 32'(bus.out_valid), 32'd1);
  endtask

  task automatic wait_drain(input int budget, input bit rnd, input string name);
    int i = 0;
    while (!all_empty() && i < budget) begin
      @(posedge clk);
      #1;
      if (rnd) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        if (!mode) sel = SEL_W'($urandom_range(0, NUM_CH - 1));
      end
      i++;
    end
    chk(name, 32'(all_empty()), 32'd1);
    bus.out_ready = 1'b1;
  endtask

  initial begin
    rst           = 1'b1;
    mode          = 1'b0;
    sel           = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  32'(bus.out_data),  32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_ch",    32'(bus.out_ch),    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: manual select of ch2, single beat
    mode = 1'b0; sel = 2'd2; bus.out_ready = 1'b1;
    push_beat(2, 1'b1, 8'hA5); ord_q.push_back(2);
    @(negedge clk);
    chk("t1_in_ready", 32'(bus.in_ready), 32'b0100);
    @(negedge clk);
    chk("t1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_out_data",  32'(bus.out_data),  32'hA5);
    chk("t1_out_ch",    32'(bus.out_ch),    32'd2);
    chk("t1_out_last",  32'(bus.out_last),  32'd1);
    wait_drain(50, 1'b0, "t1_drain");

    // 2: round-robin over four backlogged channels, no bubbles
    do_reset();
    mode = 1'b1; bus.out_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NUM_CH; k++) begin
        push_beat(k, 1'b1, DATA_W'(8'h10 + 8 * r + k));
        ord_q.push_back(k);
      end
    wait_out_valid(10, "t2_first_beat");
    for (int i = 0; i < 8; i++) begin
      chk("t2_no_bubble", 32'(bus.out_valid), 32'd1);
      @(negedge clk);
    end
    wait_drain(50, 1'b0, "t2_drain");

    // 3: multi-beat packet holds the grant, then scan continues after ch1
    do_reset();
    mode = 1'b1; bus.out_ready = 1'b1;
    push_beat(0, 1'b1, 8'h30); ord_q.push_back(0);
    wait_drain(50, 1'b0, "t3_pre_drain");
    @(posedge clk);
    #1;
    push_beat(1, 1'b0, 8'h21); push_beat(1, 1'b0, 8'h22); push_beat(1, 1'b1, 8'h23);
    push_beat(0, 1'b1, 8'h31); push_beat(3, 1'b1, 8'h33);
    ord_q.push_back(1); ord_q.push_back(1); ord_q.push_back(1);
    ord_q.push_back(3); ord_q.push_back(0);
    @(negedge clk);
    chk("t3_in_ready", 32'(bus.in_ready), 32'b0010);
    wait_drain(50, 1'b0, "t3_drain");

    // 4: backpressure holds the output and blocks all inputs
    do_reset();
    mode = 1'b1; bus.out_ready = 1'b0;
    push_beat(0, 1'b1, 8'h55); push_beat(1, 1'b1, 8'h56);
    ord_q.push_back(0); ord_q.push_back(1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t4_hold_data",  32'(bus.out_data),  32'h55);
      chk("t4_in_ready",   32'(bus.in_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t4_resume_in_ready", 32'(bus.in_ready), 32'b0010);
    @(negedge clk);
    chk("t4_next_valid", 32'(bus.out_valid), 32'd1);
    chk("t4_next_data",  32'(bus.out_data),  32'h56);
    wait_drain(50, 1'b0, "t4_drain");

    // 5: sel change mid-packet is ignored until the last beat
    do_reset();
    mode = 1'b0; sel = 2'd0; bus.out_ready = 1'b1;
    push_beat(0, 1'b0, 8'h50); push_beat(0, 1'b1, 8'h51); push_beat(3, 1'b1, 8'h53);
    ord_q.push_back(0); ord_q.push_back(0); ord_q.push_back(3);
    @(posedge clk);
    #1;
    sel = 2'd3;
    @(negedge clk);
    chk("t5_locked_in_ready", 32'(bus.in_ready), 32'b0001);
    @(negedge clk);
    chk("t5_beat2_data", 32'(bus.out_data), 32'h51);
    chk("t5_beat2_ch",   32'(bus.out_ch),   32'd0);
    wait_drain(50, 1'b0, "t5_drain");

    // 6: reset while locked on ch2 discards the packet and restarts rr at ch0
    do_reset();
    mode = 1'b1; bus.out_ready = 1'b1;
    push_beat(2, 1'b0, 8'h60); push_beat(2, 1'b0, 8'h61);
    push_beat(2, 1'b0, 8'h62); push_beat(2, 1'b1, 8'h63);
    ord_q.push_back(2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    clear_queues();
    @(negedge clk);
    chk("t6_in_ready_rst", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t6_out_valid_rst", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_beat(2, 1'b1, 8'h64); push_beat(0, 1'b1, 8'h40);
    ord_q.push_back(0); ord_q.push_back(2);
    @(negedge clk);
    chk("t6_first_grant", 32'(bus.in_ready), 32'b0001);
    wait_drain(50, 1'b0, "t6_drain");

    // Random round-robin then random manual select, with gaps and backpressure
    for (int m = 1; m >= 0; m--) begin
      do_reset();
      mode   = m[0];
      gap_en = 1'b1;
      for (int k = 0; k < NUM_CH; k++)
        for (int p = 0; p < 8; p++) begin
          int len;
          len = int'($urandom_range(1, 4));
          for (int b = 0; b < len; b++)
            push_beat(k, (b == len - 1), DATA_W'($urandom));
        end
      wait_drain(3000, 1'b1, "random_drain");
      gap_en = 1'b0;
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
